// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, instruction phases,
// and the ALU-operation classifier used by the sequencer and the ALU.
package cpu_pkg;

  localparam int PHASES = 8;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(opcode_e op);
    case (op)
      ADD, AND, XOR, LDA: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_phase_cnt.sv
// 3-bit instruction phase counter. Advances when enabled and not held,
// wrapping 7 -> 0 naturally; synchronous reset returns it to phase 0.
module cpu_ctrl_phase_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       hold,
  output logic [2:0] phase
);

  logic [2:0] phase_q;
  logic [2:0] phase_d;

  // Next phase: step by one unless frozen by ena or hold.
  always_comb begin
    phase_d = phase_q;
    if (ena && !hold) begin
      phase_d = phase_q + 3'd1;
    end
  end

  // Phase register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 3'd0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/cpu_ctrl_seq.sv
// 8-phase instruction sequencer for the accumulator CPU.
// Decodes (phase, opcode, zero) into memory/IR/PC/accumulator strobes and
// keeps a sticky halted flag. Optional single-step mode is enabled by
// defining CPU_CTRL_SINGLE_STEP_EN, which adds the step input.
module cpu_ctrl_seq
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       mem_rd,
  output logic       load_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       load_ac,
  output logic       load_pc,
  output logic       mem_wr,
  output logic [2:0] phase
);

  opcode_e    op;
  phase_e     ph;
  logic [2:0] cnt_phase;
  logic       aluop;
  logic       hlt_now;
  logic       cnt_hold;
  logic       gate;
  logic       halted_q;
  logic       halted_d;

  assign op      = opcode_e'(opcode);
  assign ph      = phase_e'(cnt_phase);
  assign aluop   = is_aluop(op);
  // HLT is recognised in the operand-address phase; the counter must not
  // advance on that same edge so that the halted phase reads back as 4.
  assign hlt_now = (ph == OP_ADDR) && (op == HLT);

`ifdef CPU_CTRL_SINGLE_STEP_EN
  logic parked_q;
  logic parked_d;
  logic wrap;

  assign cnt_hold = halted_q || hlt_now || parked_q;
  assign wrap     = ena && !cnt_hold && (ph == STORE);
  assign gate     = halted_q || parked_q;

  // Park in INST_ADDR after each instruction unless step keeps us running.
  always_comb begin
    parked_d = parked_q;
    if (parked_q && ena && step) begin
      parked_d = 1'b0;
    end else if (wrap && !step) begin
      parked_d = 1'b1;
    end
  end

  // Parked flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      parked_q <= 1'b0;
    end else begin
      parked_q <= parked_d;
    end
  end
`else
  assign cnt_hold = halted_q || hlt_now;
  assign gate     = halted_q;
`endif

  cpu_ctrl_phase_cnt u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .hold  (cnt_hold),
    .phase (cnt_phase)
  );

  // Halted flag becomes sticky once HLT is seen with the sequencer enabled.
  always_comb begin
    halted_d = halted_q;
    if (ena && hlt_now) begin
      halted_d = 1'b1;
    end
  end

  // Halted flag register; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Strobe decode; everything is forced low during reset and while halted.
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    halt    = !rst && (halted_q || hlt_now);
    if (!rst && !gate) begin
      case (ph)
        INST_FETCH: begin
          mem_rd = 1'b1;
        end
        INST_LOAD, IDLE: begin
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
        end
        OP_FETCH: begin
          mem_rd = aluop;
        end
        ALU_OP: begin
          mem_rd  = aluop;
          load_ac = aluop;
          inc_pc  = (op == SKZ) && zero;
          load_pc = (op == JMP);
        end
        STORE: begin
          mem_rd  = aluop;
          load_ac = aluop;
          inc_pc  = (op == JMP);
          load_pc = (op == JMP);
          mem_wr  = (op == STO);
        end
        default: begin
          mem_rd = 1'b0;
        end
      endcase
    end
  end

  assign phase = cnt_phase;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: a phase/halt model checked every cycle, plus
// literal per-phase strobe patterns for each instruction class.
module tb_cpu_ctrl_seq;

  localparam logic [2:0] O_HLT = 3'd0, O_SKZ = 3'd1, O_ADD = 3'd2, O_AND = 3'd3;
  localparam logic [2:0] O_XOR = 3'd4, O_LDA = 3'd5, O_STO = 3'd6, O_JMP = 3'd7;

  logic       clk = 1'b0;
  logic       rst, ena, zero;
  logic [2:0] opcode;
  logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
  logic [2:0] phase;

  int vectors    = 0;
  int miscompares = 0;

  int m_ph    = 0;
  bit m_hlt   = 1'b0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  cpu_ctrl_seq dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .opcode  (opcode),
    .zero    (zero),
    .mem_rd  (mem_rd),
    .load_ir (load_ir),
    .halt    (halt),
    .inc_pc  (inc_pc),
    .load_ac (load_ac),
    .load_pc (load_pc),
    .mem_wr  (mem_wr),
    .phase   (phase)
  );

  // Model of the instruction timeline: one step per enabled clock, HLT freezes at 4.
  always @(posedge clk) begin
    if (rst) begin
      m_ph    = 0;
      m_hlt   = 1'b0;
      m_valid = 1'b1;
    end else if (ena && !m_hlt) begin
      if (m_ph == 4 && opcode == O_HLT) m_hlt = 1'b1;
      else m_ph = (m_ph + 1) % 8;
    end
  end

  // Expected {mem_rd,load_ir,halt,inc_pc,load_ac,load_pc,mem_wr} from the instruction rules.
  function automatic logic [6:0] expect_strobes(int ph, bit hl, bit r, logic [2:0] op, bit z);
    bit alu, h;
    logic [6:0] s;
    if (r) return 7'b0;
    alu = (op == O_ADD) || (op == O_AND) || (op == O_XOR) || (op == O_LDA);
    h   = hl || (ph == 4 && op == O_HLT);
    s   = 7'b0;
    s[4] = h;
    if (!hl) begin
      s[6] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
      s[5] = (ph == 2) || (ph == 3);
      s[3] = (ph == 4) || (ph == 6 && op == O_SKZ && z) || (ph == 7 && op == O_JMP);
      s[2] = (ph >= 6) && alu;
      s[1] = (ph >= 6) && (op == O_JMP);
      s[0] = (ph == 7) && (op == O_STO);
    end
    return s;
  endfunction

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [6:0] exp_s, act_s;
    if (m_valid) begin
      exp_s = expect_strobes(m_ph, m_hlt, rst, opcode, zero);
      act_s = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
      vectors++;
      if (act_s !== exp_s || phase !== 3'(m_ph)) begin
        miscompares++;
        $display("FAIL cycle t=%0t op=%0d: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
                 $time, opcode, phase, act_s, m_ph, exp_s);
      end else begin
        $display("cycle t=%0t op=%0d phase=%0d strobes=%b ok", $time, opcode, phase, act_s);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, exp_v);
    end else begin
      $display("check %s = %b ok", name, act);
    end
  endtask

  // Runs one instruction from phase 0, recording each strobe per phase (bit i = phase i).
  task automatic run8(input logic [2:0] op, input logic z,
                      output logic [7:0] mrd, output logic [7:0] lir, output logic [7:0] inc,
                      output logic [7:0] lac, output logic [7:0] lpc, output logic [7:0] mwr);
    opcode = op;
    zero   = z;
    mrd = '0; lir = '0; inc = '0; lac = '0; lpc = '0; mwr = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mrd[i] = mem_rd; lir[i] = load_ir; inc[i] = inc_pc;
      lac[i] = load_ac; lpc[i] = load_pc; mwr[i] = mem_wr;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] mrd, lir, inc, lac, lpc, mwr;
    bit lac_seen;
    rst = 1'b1; ena = 1'b1; opcode = O_ADD; zero = 1'b0;

    // Reset held two clocks.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_phase", {5'b0, phase}, 8'd0);
    chk("reset_strobes", {1'b0, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}, 8'd0);
    rst = 1'b0;

    // Free-running phase sequence 0..7 then 0.
    for (int i = 0; i < 8; i++) begin
      chk("phase_seq", {5'b0, phase}, 8'(i));
      @(posedge clk); #1;
    end
    chk("phase_wrap", {5'b0, phase}, 8'd0);

    run8(O_ADD, 1'b0, mrd, lir, inc, lac, lpc, mwr);
    chk("add_mem_rd", mrd, 8'b1110_1110);
    chk("add_load_ir", lir, 8'b0000_1100);
    chk("add_inc_pc", inc, 8'b0001_0000);
    chk("add_load_ac", lac, 8'b1100_0000);
    chk("add_mem_wr", mwr, 8'b0000_0000);

    run8(O_SKZ, 1'b1, mrd, lir, inc, lac, lpc, mwr);
    chk("skz1_inc_pc", inc, 8'b0101_0000);
    chk("skz1_load_ac", lac, 8'b0000_0000);
    chk("skz1_mem_wr", mwr, 8'b0000_0000);
    run8(O_SKZ, 1'b0, mrd, lir, inc, lac, lpc, mwr);
    chk("skz0_inc_pc", inc, 8'b0001_0000);

    run8(O_JMP, 1'b0, mrd, lir, inc, lac, lpc, mwr);
    chk("jmp_load_pc", lpc, 8'b1100_0000);
    chk("jmp_inc_pc", inc, 8'b1001_0000);
    run8(O_STO, 1'b0, mrd, lir, inc, lac, lpc, mwr);
    chk("sto_mem_wr", mwr, 8'b1000_0000);
    chk("sto_load_ac", lac, 8'b0000_0000);
    run8(O_XOR, 1'b1, mrd, lir, inc, lac, lpc, mwr);
    chk("xor_load_ac", lac, 8'b1100_0000);

    // HLT: sticky halt at phase 4 for 20 clocks, cleared only by reset.
    opcode = O_HLT;
    repeat (4) begin @(posedge clk); #1; end
    chk("hlt_halt_ph4", {7'b0, halt}, 8'd1);
    repeat (20) begin @(posedge clk); #1; end
    chk("hlt_phase_stuck", {5'b0, phase}, 8'd4);
    chk("hlt_halt_sticky", {7'b0, halt}, 8'd1);
    chk("hlt_inc_pc_off", {7'b0, inc_pc}, 8'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("hlt_rst_phase", {5'b0, phase}, 8'd0);
    chk("hlt_rst_halt", {7'b0, halt}, 8'd0);

    // LDA interrupted by reset at phase 5: accumulator never loads.
    opcode = O_LDA;
    lac_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (load_ac) lac_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("lda_at_ph5", {5'b0, phase}, 8'd5);
    rst = 1'b1;
    if (load_ac) lac_seen = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (load_ac) lac_seen = 1'b1;
    chk("lda_rst_phase", {5'b0, phase}, 8'd0);
    chk("lda_no_load_ac", {7'b0, lac_seen}, 8'd0);

    // ena low at phase 3 for 5 clocks freezes the phase.
    repeat (3) begin @(posedge clk); #1; end
    ena = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("ena_hold_phase", {5'b0, phase}, 8'd3);
    chk("ena_hold_load_ir", {7'b0, load_ir}, 8'd1);
    ena = 1'b1;
    @(posedge clk); #1;
    chk("ena_resume_phase", {5'b0, phase}, 8'd4);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
